uart_boot_ctrl: RTL

- Parametrised UART bootloader and master-sequencing controller between uart_rx/uart_tx and the core's instruction-memory write port.
- Sequences boot → idle → load → run and sends multi-byte handshake frames to the host.
- Assembles little-endian words of configurable width into IMEM and flags overflow and partial-word timeout.
- Muxes TX ownership to the core once running; issues a one-cycle core start pulse.

---
 rtl/boot_pkg.sv | 21 ++
 rtl/boot_hs_sender.sv | 88 ++++++++
 rtl/uart_boot_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot controller.
package boot_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT,
    HS_SEND,
    IDLE,
    LOAD,
    RUN
  } boot_state_e;

  localparam logic [7:0] HS_BOOT = 8'h01;
  localparam logic [7:0] HS_LOAD = 8'h02;
  localparam logic [7:0] HS_RUN  = 8'h03;
  localparam logic [7:0] HS_ERR  = 8'h04;

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boot_hs_sender.sv
// Sends one handshake frame byte by byte, pacing each byte on tx_active.
module boot_hs_sender
  import boot_pkg::*;
#(
  parameter int HS_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [7:0]               code,
  input  logic [HS_BYTES-1:0][7:0] pad,
  input  logic                     tx_active,
  output logic [7:0]               tx_data,
  output logic                     tx_dv,
  output logic                     done
);

  localparam int IW = cnt_w(HS_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } snd_e;

  snd_e                     st_q, st_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [HS_BYTES-1:0][7:0] frm_q, frm_d;
  logic [7:0]               byte_q, byte_d;
  logic                     last;

  assign last = (idx_q == IW'(HS_BYTES - 1));

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    frm_d  = frm_q;
    byte_d = byte_q;
    done   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (go) begin
          frm_d    = pad;
          frm_d[0] = code;
          idx_d    = '0;
          st_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx_active) begin
          byte_d = frm_q[idx_q];
          st_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tx_active) begin
          if (last) begin
            done = 1'b1;
            st_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
            st_d  = S_WAIT;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      idx_q  <= '0;
      frm_q  <= '0;
      byte_q <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      frm_q  <= frm_d;
      byte_q <= byte_d;
    end
  end

  // Strobe is masked once the UART accepts, so it never overlaps busy.
  assign tx_dv   = (st_q == S_HOLD) && !tx_active;
  assign tx_data = byte_q;

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART bootloader: boot/idle/load/run sequencing and IMEM word assembly.
// Optional BOOT_CHECKSUM_EN puts byte sum and word count in the run frame.
module uart_boot_ctrl
  import boot_pkg::*;
#(
  parameter int WORD_BYTES      = 4,
  parameter int ADDR_W          = 6,
  parameter int HS_BYTES        = 4,
  parameter int RESET_WAIT_CLKS = 10,
  parameter int TIMEOUT_CLKS    = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              rx_data,
  input  logic                    rx_dv,
  input  logic                    tx_active,
  input  logic [7:0]              core_tx_data,
  input  logic                    core_tx_start,
  output logic [7:0]              tx_data,
  output logic                    tx_dv,
  output logic                    imem_we,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [8*WORD_BYTES-1:0] imem_wdata,
  output logic                    core_start,
  output logic                    load_mode,
  output logic                    run_mode,
  output logic                    err
);

  localparam int CW = cnt_w(WORD_BYTES);
  localparam int WW = cnt_w(RESET_WAIT_CLKS);
  localparam int TW = cnt_w(TIMEOUT_CLKS);

`ifdef BOOT_CHECKSUM_EN
  if (HS_BYTES < 3) begin : g_hs_chk
    $error("BOOT_CHECKSUM_EN needs HS_BYTES >= 3");
  end
`endif

  boot_state_e state_q, state_d;
  boot_state_e ret_q, ret_d;
  logic [7:0]  code_q, code_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [TW-1:0] to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_BYTES-1:0][7:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d;
  logic err_q, err_d;
  logic pend_q, pend_d;
  logic rel_q, rel_d;
  logic cs_q, cs_d;
  logic s1_q, s2_q, prev_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic start_edge;
  logic load_act;
  logic leave_load;
  logic accept;
  logic hs_go;
  logic [HS_BYTES-1:0][7:0] hs_pad;
  logic [7:0] hs_data;
  logic hs_dv;
  logic hs_done;

  assign start_edge = s2_q && !prev_q;
  // Bytes keep landing while the overflow frame is in flight.
  assign load_act = (state_q == LOAD) ||
                    ((state_q == HS_SEND) && (code_q == HS_ERR));

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    code_d     = code_q;
    wait_d     = wait_q;
    to_d       = to_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    err_d      = err_q;
    pend_d     = pend_q;
    rel_d      = rel_q;
    hs_go      = 1'b0;
    hs_pad     = '0;
    leave_load = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (state_q)
      RESET_WAIT: begin
        if (wait_q == WW'(RESET_WAIT_CLKS - 1)) begin
          hs_go   = 1'b1;
          code_d  = HS_BOOT;
          ret_d   = IDLE;
          state_d = HS_SEND;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      HS_SEND: begin
        if (hs_done) state_d = ret_q;
      end
      IDLE: begin
        if (start_edge) begin
          hs_go   = 1'b1;
          code_d  = HS_LOAD;
          ret_d   = LOAD;
          state_d = HS_SEND;
          rel_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (!s2_q) rel_d = 1'b1;
        if (start_edge && rel_q) begin
          leave_load = 1'b1;
          hs_go      = 1'b1;
          code_d     = HS_RUN;
          ret_d      = RUN;
          state_d    = HS_SEND;
`ifdef BOOT_CHECKSUM_EN
          hs_pad[1]  = sum_q;
          hs_pad[2]  = 8'(addr_q);
`endif
        end else if (pend_q) begin
          hs_go   = 1'b1;
          code_d  = HS_ERR;
          ret_d   = LOAD;
          state_d = HS_SEND;
          pend_d  = 1'b0;
        end
      end
      RUN: ;
      default: state_d = RESET_WAIT;
    endcase

    if (we_q) addr_d = addr_q + ADDR_W'(1);

    accept = load_act && rx_dv && !leave_load;
    if (accept) begin
      word_d[cnt_q] = rx_data;
      to_d          = '0;
`ifdef BOOT_CHECKSUM_EN
      sum_d         = sum_q + rx_data;
`endif
      if (cnt_q == CW'(WORD_BYTES - 1)) begin
        cnt_d = '0;
        we_d  = 1'b1;
        if (&addr_q) begin
          err_d  = 1'b1;
          pend_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (load_act && (cnt_q != '0)) begin
      if (to_q == TW'(TIMEOUT_CLKS - 1)) begin
        cnt_d = '0;
        to_d  = '0;
        err_d = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end else begin
      to_d = '0;
    end

    cs_d = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_WAIT;
      ret_q   <= RESET_WAIT;
      code_q  <= '0;
      wait_q  <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      rel_q   <= 1'b0;
      cs_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      code_q  <= code_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      rel_q   <= rel_d;
      cs_q    <= cs_d;
      s1_q    <= start;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif

  boot_hs_sender #(
    .HS_BYTES(HS_BYTES)
  ) u_hs (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (hs_go),
    .code     (code_d),
    .pad      (hs_pad),
    .tx_active(tx_active),
    .tx_data  (hs_data),
    .tx_dv    (hs_dv),
    .done     (hs_done)
  );

  assign run_mode   = (state_q == RUN);
  assign load_mode  = load_act;
  assign tx_data    = run_mode ? core_tx_data : hs_data;
  assign tx_dv      = run_mode ? core_tx_start : hs_dv;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign core_start = cs_q;
  assign err        = err_q;

endmodule
